apb_stream_bridge: RTL

- Parametrised APB slave bridging the Cortex-M1 APB bus to NCH independent byte-stream channels (CDC/UART-class data paths).
- Each channel has its own RX FIFO (stream to CPU) and TX FIFO (CPU to stream), status/control registers and sticky error flags.
- All channels share one level interrupt routed to an EXTINT bit.

---
 rtl/apb_stream_bridge.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/apb_stream_bridge.sv
// APB slave exposing NCH byte-stream channels, each with an RX and a TX show-ahead FIFO,
// status/control registers, sticky overflow flags and a shared registered interrupt.
module apb_stream_bridge #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [11:0]         PADDR,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [NCH-1:0]      rx_tvalid,
    input  logic [NCH*DW-1:0]   rx_tdata,
    output logic [NCH-1:0]      tx_tvalid,
    input  logic [NCH-1:0]      tx_tready,
    output logic [NCH*DW-1:0]   tx_tdata,
    output logic                intr
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = LW - 1;

    logic          access;
    logic [7:0]    ch_idx;
    logic          idx_ok;
    logic [1:0]    reg_off;
    logic [NCH*32-1:0] ch_rdata;
    logic [NCH-1:0]    ch_irq;
    logic          intr_q;
    logic          intr_d;
    logic          unused_bits;

    assign access      = PSEL & PENABLE;
    assign ch_idx      = PADDR[11:4];
    assign idx_ok      = ch_idx < 8'(NCH);
    assign reg_off     = PADDR[3:2];
    assign PREADY      = 1'b1;
    assign PSLVERR     = access && !idx_ok;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic          sel;
        logic          data_wr;
        logic          data_rd;
        logic          ctrl_wr;
        logic          int_wr;
        logic          rx_flush;
        logic          tx_flush;
        logic [DW-1:0] rx_mem_q [DEPTH];
        logic [DW-1:0] tx_mem_q [DEPTH];
        logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
        logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
        logic [LW-1:0] rx_level_q, rx_level_d, tx_level_q, tx_level_d;
        logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
        logic [3:0]    int_en_q, int_en_d;
        logic          rx_empty, rx_full, tx_empty, tx_full;
        logic          rx_push, rx_pop, tx_push, tx_pop;
        logic [DW-1:0] rx_in, rx_head, tx_head;
        logic [3:0]    int_stat;
        logic [31:0]   rdata;

        assign sel      = access && (ch_idx == 8'(c));
        assign data_wr  = sel && PWRITE && (reg_off == 2'd0);
        assign data_rd  = sel && !PWRITE && (reg_off == 2'd0);
        assign ctrl_wr  = sel && PWRITE && (reg_off == 2'd2);
        assign int_wr   = sel && PWRITE && (reg_off == 2'd3);
        assign rx_flush = ctrl_wr && PWDATA[8];
        assign tx_flush = ctrl_wr && PWDATA[9];

        assign rx_in    = rx_tdata[c*DW +: DW];
        assign rx_head  = rx_mem_q[rx_rd_ptr_q];
        assign tx_head  = tx_mem_q[tx_rd_ptr_q];
        assign rx_empty = (rx_level_q == '0);
        assign rx_full  = (rx_level_q == LW'(DEPTH));
        assign tx_empty = (tx_level_q == '0);
        assign tx_full  = (tx_level_q == LW'(DEPTH));

        // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
        assign rx_pop   = data_rd && !rx_empty;
        assign rx_push  = rx_tvalid[c] && (!rx_full || rx_pop) && !rx_flush;
        assign tx_pop   = !tx_empty && tx_tready[c];
        assign tx_push  = data_wr && (!tx_full || tx_pop) && !tx_flush;

        assign int_stat = {tx_ovf_q, rx_ovf_q, tx_empty, !rx_empty};

        always_comb begin
            rx_wr_ptr_d = rx_wr_ptr_q + PW'(rx_push);
            rx_rd_ptr_d = rx_rd_ptr_q + PW'(rx_pop);
            rx_level_d  = rx_level_q + LW'(rx_push) - LW'(rx_pop);
            tx_wr_ptr_d = tx_wr_ptr_q + PW'(tx_push);
            tx_rd_ptr_d = tx_rd_ptr_q + PW'(tx_pop);
            tx_level_d  = tx_level_q + LW'(tx_push) - LW'(tx_pop);
            if (rx_flush) begin
                rx_wr_ptr_d = '0;
                rx_rd_ptr_d = '0;
                rx_level_d  = '0;
            end
            if (tx_flush) begin
                tx_wr_ptr_d = '0;
                tx_rd_ptr_d = '0;
                tx_level_d  = '0;
            end
            // A new overflow outranks a same-cycle write-1-to-clear.
            rx_ovf_d = (rx_tvalid[c] && rx_full && !rx_pop && !rx_flush)
                     || (rx_ovf_q && !(int_wr && PWDATA[2]));
            tx_ovf_d = (data_wr && tx_full && !tx_pop && !tx_flush)
                     || (tx_ovf_q && !(int_wr && PWDATA[3]));
            int_en_d = ctrl_wr ? PWDATA[3:0] : int_en_q;
        end

        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                rx_wr_ptr_q <= '0;
                rx_rd_ptr_q <= '0;
                rx_level_q  <= '0;
                tx_wr_ptr_q <= '0;
                tx_rd_ptr_q <= '0;
                tx_level_q  <= '0;
                rx_ovf_q    <= 1'b0;
                tx_ovf_q    <= 1'b0;
                int_en_q    <= '0;
            end else begin
                rx_wr_ptr_q <= rx_wr_ptr_d;
                rx_rd_ptr_q <= rx_rd_ptr_d;
                rx_level_q  <= rx_level_d;
                tx_wr_ptr_q <= tx_wr_ptr_d;
                tx_rd_ptr_q <= tx_rd_ptr_d;
                tx_level_q  <= tx_level_d;
                rx_ovf_q    <= rx_ovf_d;
                tx_ovf_q    <= tx_ovf_d;
                int_en_q    <= int_en_d;
            end
        end

        always_ff @(posedge PCLK) begin
            if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_in;
            if (tx_push) tx_mem_q[tx_wr_ptr_q] <= PWDATA[DW-1:0];
        end

        always_comb begin
            rdata = '0;
            case (reg_off)
                2'd0: if (!rx_empty) rdata[DW-1:0] = rx_head;
                2'd1: begin
                    rdata[LW-1:0]  = rx_level_q;
                    rdata[8 +: LW] = tx_level_q;
                    rdata[16]      = rx_empty;
                    rdata[17]      = rx_full;
                    rdata[18]      = tx_empty;
                    rdata[19]      = tx_full;
                end
                2'd2: rdata[3:0] = int_en_q;
                default: rdata[3:0] = int_stat;
            endcase
        end

        assign ch_rdata[c*32 +: 32]  = rdata;
        assign ch_irq[c]             = |(int_stat & int_en_q);
        assign tx_tvalid[c]          = !tx_empty;
        assign tx_tdata[c*DW +: DW]  = tx_head;
    end

    always_comb begin
        PRDATA = '0;
        for (int c = 0; c < NCH; c++) begin
            if (access && (ch_idx == 8'(c))) PRDATA = ch_rdata[c*32 +: 32];
        end
    end

    assign intr_d = |ch_irq;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) intr_q <= 1'b0;
        else        intr_q <= intr_d;
    end

    assign intr = intr_q;

endmodule
